// File: rtl/frame_sequencer_if.sv
// Handshake/status bundle between the frame sequencer and its image datapath.
// FRAME_REPEAT_EN adds the frame_count status field.
interface frame_sequencer_if #(
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512
);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(3 * WIDTH * HEIGHT);

    logic          start;
    logic          out_ready;
    logic          vsync;
    logic          hsync;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [AW-1:0] pix_addr;
    logic          busy;
    logic          frame_done;
`ifdef FRAME_REPEAT_EN
    logic [15:0]   frame_count;
`endif

    modport master (
        output start,
        output out_ready,
`ifdef FRAME_REPEAT_EN
        input  frame_count,
`endif
        input  vsync,
        input  hsync,
        input  row,
        input  col,
        input  pix_addr,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  start,
        input  out_ready,
`ifdef FRAME_REPEAT_EN
        output frame_count,
`endif
        output vsync,
        output hsync,
        output row,
        output col,
        output pix_addr,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/frame_sequencer.sv
// Frame timing controller walking a bottom-up RGB BMP buffer in pixel pairs.
// FRAME_REPEAT_EN: stream frames back to back and expose a 16-bit frame_count.
//
// state   | meaning
// --------+----------------------------------------------------
// S_IDLE  | waiting for start
// S_VSYNC | vsync high for START_UP_DELAY cycles
// S_HGAP  | idle gap of HSYNC_DELAY cycles before each row
// S_DATA  | pixel pairs transferred on each out_ready cycle
// S_DONE  | one-cycle frame_done pulse
module frame_sequencer #(
    parameter int WIDTH          = 768,
    parameter int HEIGHT         = 512,
    parameter int START_UP_DELAY = 100,
    parameter int HSYNC_DELAY    = 160
) (
    input  logic             HCLK,
    input  logic             HRESET,
    frame_sequencer_if.slave bus
);
    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);
    localparam int AW = $clog2(3 * WIDTH * HEIGHT);
    localparam int DMAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
    localparam int DW = $clog2(DMAX + 1);

    localparam logic [DW-1:0] VS_LOAD   = DW'(START_UP_DELAY - 1);
    localparam logic [DW-1:0] HG_LOAD   = DW'(HSYNC_DELAY - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 2);
    localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
    localparam logic [AW-1:0] ADDR_TOP  = AW'(3 * WIDTH * (HEIGHT - 1));
    // From the last pair of one row back to the first pair of the row above it in memory.
    localparam logic [AW-1:0] ADDR_BACK = AW'(6 * WIDTH - 6);
    localparam logic [AW-1:0] ADDR_STEP = AW'(6);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_HGAP, S_DATA, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          vsync_q, vsync_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
`ifdef FRAME_REPEAT_EN
    logic [15:0]   frame_count_q, frame_count_d;
`endif
    logic          xfer;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            addr_q       <= '0;
            vsync_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef FRAME_REPEAT_EN
            frame_count_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            addr_q       <= addr_d;
            vsync_q      <= vsync_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef FRAME_REPEAT_EN
            frame_count_q <= frame_count_d;
`endif
        end
    end

    assign xfer = (state_q == S_DATA) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_VSYNC;
                    cnt_d   = VS_LOAD;
                    row_d   = '0;
                    col_d   = '0;
                    addr_d  = ADDR_TOP;
                end
            end
            S_VSYNC: begin
                if (cnt_q == '0) begin
                    state_d = S_HGAP;
                    cnt_d   = HG_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HGAP: begin
                if (cnt_q == '0) begin
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    if (col_q != COL_LAST) begin
                        col_d  = col_q + CW'(2);
                        addr_d = addr_q + ADDR_STEP;
                    end else if (row_q == ROW_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HGAP;
                        cnt_d   = HG_LOAD;
                        row_d   = row_q + 1'b1;
                        col_d   = '0;
                        addr_d  = addr_q - ADDR_BACK;
                    end
                end
            end
            S_DONE: begin
`ifdef FRAME_REPEAT_EN
                state_d = S_VSYNC;
                cnt_d   = VS_LOAD;
                row_d   = '0;
                col_d   = '0;
                addr_d  = ADDR_TOP;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        vsync_d      = (state_d == S_VSYNC);
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_d == S_DONE);
`ifdef FRAME_REPEAT_EN
        frame_count_d = frame_count_q + ((state_d == S_DONE) ? 16'd1 : 16'd0);
`endif
    end

    assign bus.vsync      = vsync_q;
    assign bus.hsync      = xfer;
    assign bus.row        = row_q;
    assign bus.col        = col_q;
    assign bus.pix_addr   = addr_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
`ifdef FRAME_REPEAT_EN
    assign bus.frame_count = frame_count_q;
`endif
endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: expected pixel pairs are queued per frame
// and a negedge monitor pops and compares them on every hsync.
module tb_frame_sequencer;
    localparam int W = 8;
    localparam int H = 4;
    localparam int S = 3;
    localparam int G = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_sequencer_if #(.WIDTH(W), .HEIGHT(H)) bus ();

    frame_sequencer #(
        .WIDTH(W), .HEIGHT(H), .START_UP_DELAY(S), .HSYNC_DELAY(G)
    ) dut (
        .HCLK(clk),
        .HRESET(rst),
        .bus(bus)
    );

    typedef struct {
        int r;
        int c;
        int a;
    } pair_t;

    pair_t exp_q[$];
    int    done_pending = 0;
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: bottom-up BMP, 3 bytes per pixel, pairs left to right, rows top to bottom.
    task automatic push_frame();
        pair_t p;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c += 2) begin
                p.r = r;
                p.c = c;
                p.a = 3 * (W * (H - 1 - r) + c);
                exp_q.push_back(p);
            end
        end
        done_pending++;
    endtask

    always @(negedge clk) begin
        pair_t p;
        if (!rst) begin
            if (bus.hsync) begin
                if (exp_q.size() == 0) begin
                    check("pair_unexpected", 1, 0);
                end else begin
                    p = exp_q.pop_front();
                    check("pair_row", int'(bus.row), p.r);
                    check("pair_col", int'(bus.col), p.c);
                    check("pair_addr", int'(bus.pix_addr), p.a);
                end
            end
            if (bus.frame_done) begin
                check("done_expected", int'(done_pending > 0), 1);
                check("done_pairs_left", exp_q.size(), 0);
                if (done_pending > 0) done_pending--;
            end
        end
    end

    task automatic begin_frame();
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        push_frame();
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, int'(ok), 1);
    endtask

    initial begin
        int hs;
        bit ok;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vsync", int'(bus.vsync), 0);
        check("rst_hsync", int'(bus.hsync), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.frame_done), 0);
        check("rst_row", int'(bus.row), 0);
        check("rst_col", int'(bus.col), 0);
        check("rst_addr", int'(bus.pix_addr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic frame, start ignored while busy, restart from idle at cycle 30.
        bus.out_ready = 1'b1;
        begin_frame();
        hs = 0;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            #1;
            bus.start = (k == 10 || k == 30);
            if (k == 30) push_frame();
            @(negedge clk);
            check("basic_vsync", int'(bus.vsync), int'((k >= 1 && k <= S) || k == 31));
            check("basic_busy", int'(bus.busy), int'(k <= 28 || k == 31));
            check("basic_done", int'(bus.frame_done), int'(k == 28));
            if (k <= 29) hs += int'(bus.hsync);
        end
        check("basic_hsync_count", hs, H * W / 2);
        wait_idle("restart_idle_timeout");

        // Back-pressure at row 1, col 2 for five cycles.
        begin_frame();
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.out_ready = !(k >= 13 && k <= 17);
            @(negedge clk);
            if (k >= 13 && k <= 17) begin
                check("bp_hsync", int'(bus.hsync), 0);
                check("bp_row", int'(bus.row), 1);
                check("bp_col", int'(bus.col), 2);
                check("bp_addr", int'(bus.pix_addr), 54);
            end
            check("bp_done", int'(bus.frame_done), int'(k == 33));
        end
        bus.out_ready = 1'b1;
        wait_idle("bp_idle_timeout");

        // Reset during row 2 aborts the frame silently.
        begin_frame();
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            rst = (k == 17);
            if (k == 18) begin
                exp_q.delete();
                done_pending = 0;
            end
            @(negedge clk);
            if (k == 18) begin
                check("abort_vsync", int'(bus.vsync), 0);
                check("abort_hsync", int'(bus.hsync), 0);
                check("abort_busy", int'(bus.busy), 0);
                check("abort_row", int'(bus.row), 0);
                check("abort_col", int'(bus.col), 0);
                check("abort_addr", int'(bus.pix_addr), 0);
            end
            if (k >= 18) check("abort_no_done", int'(bus.frame_done), 0);
        end

        // Randomized back-pressure and stray start pulses while busy.
        for (int f = 0; f < 4; f++) begin
            begin_frame();
            ok = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                @(posedge clk);
                #1;
                bus.start = bus.busy && ($urandom_range(0, 7) == 0);
                bus.out_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (!bus.busy) begin
                    ok = 1'b1;
                    break;
                end
            end
            bus.start = 1'b0;
            check("rand_frame_timeout", int'(ok), 1);
        end

        check("end_pairs_left", exp_q.size(), 0);
        check("end_done_pending", done_pending, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
